// File: rtl/nn_mac_sequencer.sv
// Time-multiplexed MAC sequencer for an 8-in / 4-out neural layer.
// Streams weights from a sync ROM, then applies ReLU/scale/saturate and argmax.
module nn_mac_sequencer #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int ACCW  = 20,
  parameter int SHIFT = 4,
  localparam int NW   = N_IN * N_OUT,
  localparam int AW   = $clog2(NW),
  localparam int IW   = $clog2(N_IN),
  localparam int CW   = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_IN*DW-1:0]    x_flat,
  output logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT*DW-1:0]   out_flat,
  output logic [CW-1:0]         class_idx,
  output logic [N_OUT-1:0]      onehot
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    PUBLISH
  } state_t;

  localparam logic [AW:0]   LAST_CNT  = (AW+1)'(NW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);
  localparam int PW = 2 * DW + 1;

  state_t                   state_q, state_d;
  logic [AW:0]              cnt_q, cnt_d;
  logic [AW-1:0]            w_addr_q, w_addr_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [N_IN*DW-1:0]       x_q, x_d;
  logic [N_OUT-1:0][DW-1:0] r_q, r_d;
  logic [N_OUT-1:0][DW-1:0] out_q, out_d;
  logic [CW-1:0]            cls_q, cls_d;
  logic [N_OUT-1:0]         oh_q, oh_d;
  logic                     done_q, done_d;

  logic [AW:0]              k;
  logic [IW-1:0]            k_i;
  logic [CW-1:0]            k_j;
  logic [DW-1:0]            x_sel;
  logic signed [PW-1:0]     prod;
  logic signed [ACCW-1:0]   sum;
  logic signed [ACCW-1:0]   sh;
  logic [DW-1:0]            act;
  logic [N_OUT-1:0]         best;
  logic [CW-1:0]            win;

  // Weight k reaches w_data two edges after its count, hence the -1 lag.
  always_comb begin
    k     = cnt_q - 1'b1;
    k_i   = k[IW-1:0];
    k_j   = k[AW-1:IW];
    x_sel = x_q[k_i*DW +: DW];
    prod  = $signed({1'b0, x_sel}) * $signed(w_data);
    sum   = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
    sh    = sum >>> SHIFT;
    if (sum[ACCW-1]) begin
      act = '0;
    end else if (|sh[ACCW-1:DW]) begin
      act = '1;
    end else begin
      act = sh[DW-1:0];
    end
  end

  always_comb begin
    best = '1;
    for (int j = 0; j < N_OUT; j++) begin
      for (int m = 0; m < N_OUT; m++) begin
        if (m != j && !(r_q[j] > r_q[m])) begin
          best[j] = 1'b0;
        end
      end
    end
    // Anything without a strict winner falls through to the top class.
    win = CW'(N_OUT - 1);
    for (int j = N_OUT - 2; j >= 0; j--) begin
      if (best[j]) begin
        win = CW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_addr_d = w_addr_q;
    acc_d    = acc_q;
    x_d      = x_q;
    r_d      = r_q;
    out_d    = out_q;
    cls_d    = cls_q;
    oh_d     = oh_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MAC;
          x_d      = x_flat;
          acc_d    = '0;
          cnt_d    = '0;
          w_addr_d = '0;
        end
      end
      MAC: begin
        cnt_d = cnt_q + 1'b1;
        if (w_addr_q != LAST_ADDR) begin
          w_addr_d = w_addr_q + 1'b1;
        end
        if (cnt_q != '0) begin
          acc_d = sum;
          if (k_i == IW'(N_IN - 1)) begin
            acc_d    = '0;
            r_d[k_j] = act;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        out_d     = r_q;
        cls_d     = win;
        oh_d      = '0;
        oh_d[win] = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_addr_q <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      r_q      <= '0;
      out_q    <= '0;
      cls_q    <= '0;
      oh_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_addr_q <= w_addr_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      r_q      <= r_d;
      out_q    <= out_d;
      cls_q    <= cls_d;
      oh_q     <= oh_d;
      done_q   <= done_d;
    end
  end

  assign w_addr    = w_addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_flat  = out_q;
  assign class_idx = cls_q;
  assign onehot    = oh_q;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Randomized bench for nn_mac_sequencer against a plain arithmetic
// model of the layer, plus directed handshake and reset scenarios.
module tb_nn_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] x_flat;
  logic [4:0]  w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;
  logic [31:0] out_flat;
  logic [1:0]  class_idx;
  logic [3:0]  onehot;

  logic signed [7:0] rom [32];

  int n_chk  = 0;
  int n_pass = 0;

  nn_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_flat    (x_flat),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .out_flat  (out_flat),
    .class_idx (class_idx),
    .onehot    (onehot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [63:0] x,
                                output logic [31:0] o,
                                output logic [1:0] c);
    int s;
    int r [4];
    bit win;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int i = 0; i < 8; i++)
        s += int'(x[8*i +: 8]) * int'(rom[j*8+i]);
      if (s < 0) r[j] = 0;
      else if (s / 16 > 255) r[j] = 255;
      else r[j] = s / 16;
      o[8*j +: 8] = 8'(r[j]);
    end
    c = 2'd3;
    for (int j = 2; j >= 0; j--) begin
      win = 1;
      for (int m = 0; m < 4; m++)
        if (m != j && r[j] <= r[m]) win = 0;
      if (win) c = 2'(j);
    end
  endfunction

  function automatic logic [63:0] pack_x(input int v [8]);
    logic [63:0] x;
    for (int i = 0; i < 8; i++) x[8*i +: 8] = 8'(v[i]);
    return x;
  endfunction

  task automatic run(input logic [63:0] x, input bit pulse);
    logic [31:0] eo, prev;
    logic [1:0]  ec;
    logic [3:0]  eoh;
    int cyc;
    bit addr_ok, stable_ok, busy_ok, quiet_ok;
    model(x, eo, ec);
    eoh = 4'b0001 << ec;
    prev = out_flat;
    @(negedge clk);
    start = 1'b1;
    x_flat = x;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    addr_ok = 1; stable_ok = 1; busy_ok = 1;
    while (!done && cyc < 60) begin
      if (cyc <= 31 && w_addr != 5'(cyc)) addr_ok = 0;
      if (out_flat != prev) stable_ok = 0;
      if (!busy) busy_ok = 0;
      start = pulse && (cyc == 10 || cyc == 20);
      x_flat = {$urandom, $urandom};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'd34);
    chk("waddr_seq", 64'(addr_ok), 64'd1);
    chk("out_stable", 64'(stable_ok), 64'd1);
    chk("busy_run", 64'(busy_ok), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("out_flat", 64'(out_flat), 64'(eo));
    chk("class_idx", 64'(class_idx), 64'(ec));
    chk("onehot", 64'(onehot), 64'(eoh));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    quiet_ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) quiet_ok = 0;
      @(negedge clk);
    end
    chk("no_rerun", 64'(quiet_ok), 64'd1);
  endtask

  initial begin : main
    int v [8];
    logic [31:0] ea, eb;
    logic [1:0]  ca, cb;
    int d1, d2, nd;
    bit nodone;

    rst_n = 1'b0;
    start = 1'b0;
    x_flat = '0;
    for (int a = 0; a < 32; a++) rom[a] = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_waddr", 64'(w_addr), 64'd0);
    chk("rst_out", 64'(out_flat), 64'd0);
    chk("rst_class", 64'(class_idx), 64'd0);
    chk("rst_onehot", 64'(onehot), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '{10, 20, 15, 25, 30, 12, 22, 17};
    for (int a = 0; a < 32; a++) rom[a] = 8'(a / 8 + 1);
    run(pack_x(v), 1'b1);
    chk("nom_out", 64'(out_flat), 64'h25_1C_12_09);
    chk("nom_class", 64'(class_idx), 64'd3);

    for (int a = 0; a < 32; a++)
      rom[a] = (a < 8) ? -8'sd1 : (a < 16) ? 8'sd127 : 8'sd0;
    run(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("sat_out", 64'(out_flat), 64'h00_00_FF_00);
    chk("sat_onehot", 64'(onehot), 64'b0010);

    for (int a = 0; a < 32; a++) rom[a] = '0;
    run({$urandom, $urandom}, 1'b0);
    chk("zero_onehot", 64'(onehot), 64'b1000);

    rom[0] = 8'sd8;
    rom[8] = 8'sd8;
    run(64'(80), 1'b0);
    chk("tie_out", 64'(out_flat), 64'h00_00_28_28);
    chk("tie_class", 64'(class_idx), 64'd3);

    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 32; a++)
        rom[a] = (t < 4) ? 8'($urandom) : 8'($signed(5'($urandom)));
      run({$urandom, $urandom}, 1'(t));
    end

    for (int a = 0; a < 32; a++) rom[a] = 8'($signed(6'($urandom)));
    model(64'hF0E0_D0C0_B0A0_9080, ea, ca);
    model(64'h0102_0304_0506_0708, eb, cb);
    @(negedge clk);
    start = 1'b1;
    x_flat = 64'hF0E0_D0C0_B0A0_9080;
    nd = 0; d1 = -1; d2 = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin
          d1 = c;
          chk("held_out1", 64'(out_flat), 64'(ea));
          x_flat = 64'h0102_0304_0506_0708;
        end else if (nd == 2) begin
          d2 = c;
          chk("held_out2", 64'(out_flat), 64'(eb));
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held_d1", 64'(d1), 64'd34);
    chk("held_d2", 64'(d2), 64'd69);
    chk("held_count", 64'(nd), 64'd2);

    for (int a = 0; a < 32; a++) rom[a] = 8'sd20;
    run(64'h4040_4040_4040_4040, 1'b0);
    @(negedge clk);
    start = 1'b1;
    x_flat = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_waddr", 64'(w_addr), 64'd0);
    chk("mid_out", 64'(out_flat), 64'd0);
    chk("mid_onehot", 64'(onehot), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nodone = 1;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) nodone = 0;
      @(negedge clk);
    end
    chk("mid_nodone", 64'(nodone), 64'd1);
    for (int a = 0; a < 32; a++) rom[a] = 8'($urandom);
    run({$urandom, $urandom}, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nn_mac_sequencer.md
# nn_mac_sequencer

Sequencing controller for the 8-input / 4-output neural layer. A single shared 8x8 multiply-accumulate unit is time-multiplexed over all 32 weights, and weights are streamed from an external synchronous weight ROM. After the last weight, the block applies ReLU, scaling and saturation, then argmax. It publishes four 8-bit activations, a class index and a one-hot LED pattern to the board top level.

## Interface
- N_IN, 8: inputs per neuron.
- N_OUT, 4: neurons (outputs).
- DW, 8: input/activation width.
- ACCW, 20: signed accumulator width.
- SHIFT, 4: right-shift applied after ReLU.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to run one inference; level-sampled in IDLE only.
- x_flat  in  64  unsigned inputs; x[i] = x_flat[8i+7:8i]; latched on accepted start.
- w_addr  out  5  registered weight ROM address; weight (j,i) at j*N_IN+i.
- w_data  in  8  signed weight; valid one cycle after w_addr is presented (sync ROM).
- busy  out  1  high while an inference is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- out_flat  out  32  activations; out[j] = out_flat[8j+7:8j].
- class_idx  out  2  winning neuron index.
- onehot  out  4  LED pattern, bit j set for class j.

## Operation
- States: IDLE, MAC, PUBLISH.
- IDLE -> MAC on clock edge with start=1.
  - On that edge: latch x_flat, clear the accumulator, set the counter and w_addr to 0.
- MAC: w_addr increments 0..31, one per cycle, then holds.
  - Product x[i]*w_data is sign-correct: x is zero-extended, w is signed, result is 17-bit signed, sign-extended to ACCW.
- Neuron boundary, on the edge that accumulates weight i=7 of neuron j:
  - Final sum s = acc + product.
  - Internal result r[j] = (s<0) ? 0 : min(s>>>SHIFT, 255).
  - The accumulator reloads to 0 on the same edge.
- MAC -> PUBLISH after weight 31 is accumulated.
- PUBLISH (1 cycle), on its exit edge:
  - out_flat is loaded from r[0..3].
  - class_idx/onehot are computed with strict comparisons:
    - class 0 if r0 > r1, r2 and r3;
    - else class 1 if r1 > r0, r2 and r3;
    - else class 2 if r2 > r0, r1 and r3;
    - else class 3 (all ties resolve to class 3, onehot 4'b1000).
  - done is set for one cycle; state returns to IDLE.
- Published outputs hold their values until the next PUBLISH; they never show partial results.
- start while busy is ignored: no queueing, no restart.
- Accumulator never overflows for DW=8, N_IN=8 (|s| ≤ 8*255*128 = 261120 < 2^19).

## Timing
- E0 = edge accepting start.
- w_addr = k after edge E(k), k=0..31.
- Weight k is accumulated at E(k+2).
- r[j] is written at E(8j+9); the last one, r[3], at E33.
- PUBLISH is entered at E33.
- Outputs and done are registered at E34; done is high E34..E35.
- Latency: done rises 34 cycles after the start edge. Throughput: one inference per 35 cycles; start held high re-arms at E35.
- busy: high from E0 through E34, low after E34 (coincident with done rising).
- Reset values (rst_n=0, immediate):
  - state IDLE, busy 0, done 0, w_addr 0, accumulator 0;
  - r[] 0, out_flat 0, class_idx 0, onehot 4'b0000.
- Reset mid-inference: aborts with no done pulse; previously published outputs are cleared to 0.
- Reset release: first start accepted on the first rising edge with rst_n=1.

## Test plan
- Nominal: x = {10,20,15,25,30,12,22,17}, all weights of neuron j = j+1 -> out = {9,18,28,37}, class_idx 3, onehot 4'b1000, done exactly 34 cycles after start, w_addr sequence 0..31.
- ReLU/saturation: neuron 0 weights -1, neuron 1 weights +127 with x all 255, neurons 2/3 weights 0 -> out = {0,255,0,0}, class_idx 1, onehot 4'b0010.
- Tie rule: all weights 0 -> out all 0, class_idx 3, onehot 4'b1000; with out0=out1=40 > others -> class 3.
- Handshake: pulse start again at E10 and E20 while busy -> ignored, single done; start held high continuously -> done pulses every 35 cycles, x re-latched each run.
- Reset mid-op: assert rst_n=0 at E15 -> busy/done/w_addr/out_flat/onehot all 0 immediately, no done; new start after release completes normally with correct results.
- Output stability: change x_flat during MAC -> results reflect the x latched at E0; out_flat holds the old values until E34.
